// File: rtl/l1_dcache_pkg.sv
// ============================================================================
// Module : l1_dcache_pkg
// Brief  : Shared FSM encoding, default geometry and address field helpers
//          for the L1 data cache controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package l1_dcache_pkg;

  localparam int DEF_OFFSET_WIDTH    = 5;
  localparam int DEF_INDEX_WIDTH     = 7;
  localparam int DEF_TAG_WIDTH       = 32 - DEF_OFFSET_WIDTH - DEF_INDEX_WIDTH;
  localparam int DEF_WORDS_PER_BLOCK = 2 ** (DEF_OFFSET_WIDTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_ALLOCATE  = 2'd3
  } state_t;

  // Field extractors return right-justified fields; callers keep the low bits.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int ow, input int iw);
    return addr >> (ow + iw);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int ow, input int iw);
    return (addr >> ow) & ((32'd1 << iw) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_word(input logic [31:0] addr, input int ow);
    return (addr >> 2) & ((32'd1 << (ow - 2)) - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/l1_dcache_tag_store.sv
// ============================================================================
// Module : l1_dcache_tag_store
// Brief  : Tag, valid and dirty arrays; synchronous write, asynchronous read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module l1_dcache_tag_store
  import l1_dcache_pkg::*;
#(
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int TAG_WIDTH   = DEF_TAG_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic                   fill_enable,
  input  logic [TAG_WIDTH-1:0]   fill_tag,
  input  logic                   dirty_set,
  output logic [TAG_WIDTH-1:0]   tag,
  output logic                   valid,
  output logic                   dirty
);

  localparam int LINES = 2 ** INDEX_WIDTH;

  logic [TAG_WIDTH-1:0] r_tags [LINES];
  logic [LINES-1:0]     r_valid;
  logic [LINES-1:0]     r_dirty;

  // Tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_enable) begin
      r_tags[index] <= fill_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (fill_enable) begin
      r_valid[index] <= 1'b1;
      r_dirty[index] <= 1'b0;
    end else if (dirty_set) begin
      r_dirty[index] <= 1'b1;
    end
  end

  assign tag   = r_tags[index];
  assign valid = r_valid[index];
  assign dirty = r_dirty[index];

endmodule

`default_nettype wire

// File: rtl/l1_dcache_controller.sv
// ============================================================================
// Module : l1_dcache_controller
// Brief  : Direct-mapped write-back / write-allocate L1 D-cache sequencer.
//          Optional hit/miss counters under `DCACHE_PERF_COUNTERS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module l1_dcache_controller
  import l1_dcache_pkg::*;
#(
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_read_enable,
  input  logic                    cpu_write_enable,
  input  logic [31:0]             cpu_address,
  input  logic [31:0]             cpu_write_data,
  output logic [31:0]             cpu_read_data,
  output logic                    cpu_ready,
  output logic                    cache_miss,
  output logic [INDEX_WIDTH-1:0]  data_index,
  output logic [OFFSET_WIDTH-3:0] data_word,
  output logic                    data_write_enable,
  output logic [31:0]             data_write_data,
  input  logic [31:0]             data_read_data,
  output logic                    mem_read_enable,
  output logic                    mem_write_enable,
  output logic [31:0]             mem_address,
  output logic [31:0]             mem_write_data,
  input  logic [31:0]             mem_read_data,
  input  logic                    mmu_mem_ready
`ifdef DCACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);

  localparam int TAG_WIDTH       = 32 - OFFSET_WIDTH - INDEX_WIDTH;
  localparam int WORDS_PER_BLOCK = 2 ** (OFFSET_WIDTH - 2);
  localparam int WORD_WIDTH      = OFFSET_WIDTH - 2;
  localparam logic [WORD_WIDTH-1:0] LAST_WORD = WORD_WIDTH'(WORDS_PER_BLOCK - 1);

  state_t                r_state;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic                  r_is_write;
  logic                  r_replay;
  logic                  r_gap;
  logic [WORD_WIDTH-1:0] r_cnt;
  logic                  r_cpu_ready;
  logic                  r_cache_miss;
  logic [31:0]           r_cpu_read_data;

  logic [31:0]            w_tag_full;
  logic [31:0]            w_idx_full;
  logic [31:0]            w_word_full;
  logic [TAG_WIDTH-1:0]   w_req_tag;
  logic [INDEX_WIDTH-1:0] w_req_index;
  logic [WORD_WIDTH-1:0]  w_req_word;
  logic [TAG_WIDTH-1:0]   w_line_tag;
  logic                   w_line_valid;
  logic                   w_line_dirty;
  logic                   w_hit;
  logic                   w_xfer;
  logic                   w_last;
  logic                   w_fill;
  logic                   w_dirty_set;
  logic                   w_unused;

  assign w_tag_full  = addr_tag(r_addr, OFFSET_WIDTH, INDEX_WIDTH);
  assign w_idx_full  = addr_index(r_addr, OFFSET_WIDTH, INDEX_WIDTH);
  assign w_word_full = addr_word(r_addr, OFFSET_WIDTH);
  assign w_req_tag   = w_tag_full[TAG_WIDTH-1:0];
  assign w_req_index = w_idx_full[INDEX_WIDTH-1:0];
  assign w_req_word  = w_word_full[WORD_WIDTH-1:0];
  assign w_unused    = ^{w_tag_full[31:TAG_WIDTH], w_idx_full[31:INDEX_WIDTH],
                         w_word_full[31:WORD_WIDTH]};

  l1_dcache_tag_store #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_tag_store (
    .clk         (clk),
    .reset       (reset),
    .index       (w_req_index),
    .fill_enable (w_fill),
    .fill_tag    (w_req_tag),
    .dirty_set   (w_dirty_set),
    .tag         (w_line_tag),
    .valid       (w_line_valid),
    .dirty       (w_line_dirty)
  );

  // r_gap drops the memory request for one cycle after each completed word.
  assign w_hit       = w_line_valid && (w_line_tag == w_req_tag);
  assign w_xfer      = ((r_state == ST_WRITEBACK) || (r_state == ST_ALLOCATE)) &&
                       !r_gap && mmu_mem_ready;
  assign w_last      = (r_cnt == LAST_WORD);
  assign w_fill      = (r_state == ST_ALLOCATE) && w_xfer && w_last;
  assign w_dirty_set = (r_state == ST_COMPARE) && w_hit && r_is_write;

  always_comb begin
    data_index        = w_req_index;
    data_word         = w_req_word;
    data_write_enable = 1'b0;
    data_write_data   = 32'h0;
    mem_read_enable   = 1'b0;
    mem_write_enable  = 1'b0;
    mem_address       = 32'h0;
    mem_write_data    = 32'h0;
    case (r_state)
      ST_COMPARE: begin
        data_write_enable = w_dirty_set;
        data_write_data   = r_wdata;
      end
      ST_WRITEBACK: begin
        data_word        = r_cnt;
        mem_write_enable = !r_gap;
        mem_address      = {w_line_tag, w_req_index, r_cnt, 2'b00};
        mem_write_data   = data_read_data;
      end
      ST_ALLOCATE: begin
        data_word         = r_cnt;
        data_write_enable = w_xfer;
        data_write_data   = mem_read_data;
        mem_read_enable   = !r_gap;
        mem_address       = {w_req_tag, w_req_index, r_cnt, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_addr          <= 32'h0;
      r_wdata         <= 32'h0;
      r_is_write      <= 1'b0;
      r_replay        <= 1'b0;
      r_gap           <= 1'b0;
      r_cnt           <= '0;
      r_cpu_ready     <= 1'b0;
      r_cache_miss    <= 1'b0;
      r_cpu_read_data <= 32'h0;
    end else begin
      r_cpu_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cpu_read_enable || cpu_write_enable) begin
            r_addr     <= cpu_address;
            r_wdata    <= cpu_write_data;
            r_is_write <= cpu_write_enable;
            r_replay   <= 1'b0;
            r_state    <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (w_hit) begin
            if (!r_is_write) begin
              r_cpu_read_data <= data_read_data;
            end
            r_cpu_ready  <= 1'b1;
            r_cache_miss <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_cache_miss <= 1'b1;
            r_cnt        <= '0;
            r_gap        <= 1'b0;
            r_state      <= (w_line_valid && w_line_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
        ST_WRITEBACK, ST_ALLOCATE: begin
          if (r_gap) begin
            r_gap <= 1'b0;
          end else if (mmu_mem_ready) begin
            r_gap <= 1'b1;
            if (w_last) begin
              r_cnt <= '0;
              if (r_state == ST_WRITEBACK) begin
                r_state <= ST_ALLOCATE;
              end else begin
                r_state  <= ST_COMPARE;
                r_replay <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_ready     = r_cpu_ready;
  assign cache_miss    = r_cache_miss;
  assign cpu_read_data = r_cpu_read_data;

`ifdef DCACHE_PERF_COUNTERS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Only the first look-up of a request counts; the post-fill replay does not.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_count  <= 32'h0;
      r_miss_count <= 32'h0;
    end else if ((r_state == ST_COMPARE) && !r_replay) begin
      if (w_hit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end else begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l1_dcache_controller.sv
// ============================================================================
// Module : tb_l1_dcache_controller
// Brief  : Self-checking bench: MMU responder, data-array RAM, cache model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_l1_dcache_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read_enable, cpu_write_enable;
  logic [31:0] cpu_address, cpu_write_data, cpu_read_data;
  logic        cpu_ready, cache_miss;
  logic [6:0]  data_index;
  logic [2:0]  data_word;
  logic        data_write_enable;
  logic [31:0] data_write_data, data_read_data;
  logic        mem_read_enable, mem_write_enable;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mmu_mem_ready;
`ifdef DCACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  l1_dcache_controller dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_read_enable   (cpu_read_enable),
    .cpu_write_enable  (cpu_write_enable),
    .cpu_address       (cpu_address),
    .cpu_write_data    (cpu_write_data),
    .cpu_read_data     (cpu_read_data),
    .cpu_ready         (cpu_ready),
    .cache_miss        (cache_miss),
    .data_index        (data_index),
    .data_word         (data_word),
    .data_write_enable (data_write_enable),
    .data_write_data   (data_write_data),
    .data_read_data    (data_read_data),
    .mem_read_enable   (mem_read_enable),
    .mem_write_enable  (mem_write_enable),
    .mem_address       (mem_address),
    .mem_write_data    (mem_write_data),
    .mem_read_data     (mem_read_data),
    .mmu_mem_ready     (mmu_mem_ready)
`ifdef DCACHE_PERF_COUNTERS_EN
    ,
    .hit_count         (hit_count),
    .miss_count        (miss_count)
`endif
  );

  // Data-array RAM the controller drives through its word port.
  logic [31:0] darr [0:1023];
  assign data_read_data = darr[{data_index, data_word}];
  always @(posedge clk) if (data_write_enable) darr[{data_index, data_word}] <= data_write_data;

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat = 3;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } txn_t;
  txn_t obs_q[$];
  txn_t exp_q[$];

  logic [31:0] bmem [logic [31:0]];  // backing memory seen by the MMU
  logic [31:0] gm   [logic [31:0]];  // architectural memory seen by the CPU
  logic [19:0] mtag [128];
  bit          mvalid [128];
  bit          mdirty [128];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] bm_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] gm_rd(input logic [31:0] a);
    return gm.exists(a) ? gm[a] : init_val(a);
  endfunction

  // Reset loses whatever was dirty: the CPU view falls back to backing memory.
  task automatic model_reset();
    for (int i = 0; i < 128; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    gm = bmem;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              output logic hit, output logic [31:0] rexp);
    logic [31:0] aw, va;
    int idx;
    logic [19:0] tg;
    aw  = {a[31:2], 2'b00};
    idx = int'(a[11:5]);
    tg  = a[31:12];
    hit = mvalid[idx] && (mtag[idx] == tg);
    if (!hit) begin
      if (mvalid[idx] && mdirty[idx]) begin
        for (int w = 0; w < 8; w++) begin
          va = (32'(mtag[idx]) << 12) | 32'(idx * 32 + w * 4);
          exp_q.push_back('{1'b1, va, gm_rd(va)});
        end
      end
      for (int w = 0; w < 8; w++) begin
        exp_q.push_back('{1'b0, (32'(tg) << 12) | 32'(idx * 32 + w * 4), 32'h0});
      end
      mtag[idx]   = tg;
      mvalid[idx] = 1'b1;
      mdirty[idx] = 1'b0;
    end
    if (we) begin
      gm[aw]      = wd;
      mdirty[idx] = 1'b1;
    end
    rexp = gm_rd(aw);
  endtask

  // MMU responder: completes a word mem_lat cycles after the request appears.
  initial begin
    int lat_cnt;
    lat_cnt       = 0;
    mmu_mem_ready = 1'b0;
    mem_read_data = 32'h0;
    forever begin
      @(negedge clk);
      if (mmu_mem_ready) begin
        mmu_mem_ready = 1'b0;
        lat_cnt       = 0;
        check_val("req_gap", {31'b0, mem_read_enable | mem_write_enable}, 32'h0);
      end else if (!reset && (mem_read_enable || mem_write_enable)) begin
        lat_cnt++;
        if (lat_cnt >= mem_lat) begin
          mmu_mem_ready = 1'b1;
          if (mem_write_enable) begin
            bmem[mem_address] = mem_write_data;
            obs_q.push_back('{1'b1, mem_address, mem_write_data});
          end else begin
            mem_read_data = bm_rd(mem_address);
            obs_q.push_back('{1'b0, mem_address, 32'h0});
          end
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    cpu_read_enable  = 1'b0;
    cpu_write_enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_req(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] wd, input string nm);
    logic hit;
    logic [31:0] rexp, rd_before;
    int cyc;
    bit seen_miss, done;
    model_access(we, a, wd, hit, rexp);
    rd_before = cpu_read_data;
    @(negedge clk);
    cpu_read_enable  = re;
    cpu_write_enable = we;
    cpu_address      = a;
    cpu_write_data   = wd;
    cyc = 0; seen_miss = 1'b0; done = 1'b0;
    while (!done && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cache_miss) seen_miss = 1'b1;
      if (cpu_ready) done = 1'b1;
    end
    check_val({nm, "_ready"}, {31'b0, done}, 32'h1);
    check_val({nm, "_miss_clr"}, {31'b0, cache_miss}, 32'h0);
    check_val({nm, "_miss"}, {31'b0, seen_miss}, {31'b0, !hit});
    if (hit) check_val({nm, "_lat"}, cyc, 32'd2);
    if (we) check_val({nm, "_rd_hold"}, cpu_read_data, rd_before);
    else    check_val({nm, "_rdata"}, cpu_read_data, rexp);
    @(negedge clk);
    cpu_read_enable  = 1'b0;
    cpu_write_enable = 1'b0;
    check_val({nm, "_ntxn"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check_val({nm, "_twe"}, {31'b0, obs_q[i].we}, {31'b0, exp_q[i].we});
      check_val({nm, "_taddr"}, obs_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we) check_val({nm, "_tdata"}, obs_q[i].data, exp_q[i].data);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    reset = 1'b1;
    cpu_read_enable = 1'b0; cpu_write_enable = 1'b0;
    cpu_address = 32'h0; cpu_write_data = 32'h0;
    reset_dut();

    #1;
    check_val("rst_ready", {31'b0, cpu_ready}, 32'h0);
    check_val("rst_miss", {31'b0, cache_miss}, 32'h0);
    check_val("rst_mre", {31'b0, mem_read_enable}, 32'h0);
    check_val("rst_mwe", {31'b0, mem_write_enable}, 32'h0);
    check_val("rst_dwe", {31'b0, data_write_enable}, 32'h0);
    check_val("rst_rdata", cpu_read_data, 32'h0);
    check_val("rst_maddr", mem_address, 32'h0);
    check_val("rst_mwdata", mem_write_data, 32'h0);

    mem_lat = 3;
    do_req(1'b0, 1'b1, 32'h0000_1000, 32'h0, "fill");
    do_req(1'b1, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, "wr_hit");
    do_req(1'b0, 1'b1, 32'h0000_1004, 32'h0, "rd_hit");
    do_req(1'b0, 1'b1, 32'h0001_1004, 32'h0, "evict");
    check_val("wb_word1", bm_rd(32'h0000_1004), 32'hDEAD_BEEF);

    // Reset while the fourth refill word is outstanding.
    @(negedge clk);
    cpu_read_enable = 1'b1;
    cpu_address     = 32'h0000_4040;
    cyc = 0;
    while (cyc < 400 && !(obs_q.size() == 3 && mem_read_enable)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val("rst_reach4", obs_q.size(), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    cpu_read_enable = 1'b0;
    @(posedge clk);
    #1;
    check_val("midrst_mre", {31'b0, mem_read_enable}, 32'h0);
    check_val("midrst_mwe", {31'b0, mem_write_enable}, 32'h0);
    check_val("midrst_miss", {31'b0, cache_miss}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    do_req(1'b0, 1'b1, 32'h0000_4040, 32'h0, "refetch");

    do_req(1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, "both_en");
    do_req(1'b0, 1'b1, 32'h0000_2000, 32'h0, "both_rd");
    do_req(1'b0, 1'b1, 32'h0000_3000, 32'h0, "both_evict");

    for (int k = 0; k < 60; k++) begin
      int tg, ix, w, lo, op;
      tg = int'($urandom_range(0, 3));
      ix = int'($urandom_range(0, 3));
      w  = int'($urandom_range(0, 7));
      lo = int'($urandom_range(0, 3));
      op = int'($urandom_range(0, 2));
      mem_lat = int'($urandom_range(1, 3));
      do_req(op != 0, op != 1, 32'((tg + 8) * 4096 + ix * 32 + w * 4 + lo), $urandom, "rnd");
    end

`ifdef DCACHE_PERF_COUNTERS_EN
    reset_dut();
    check_val("perf_rst_hit", hit_count, 32'd0);
    check_val("perf_rst_miss", miss_count, 32'd0);
    do_req(1'b0, 1'b1, 32'h0000_5000, 32'h0, "perf_m");
    do_req(1'b0, 1'b1, 32'h0000_5000, 32'h0, "perf_h1");
    do_req(1'b0, 1'b1, 32'h0000_5004, 32'h0, "perf_h2");
    check_val("perf_hit", hit_count, 32'd2);
    check_val("perf_miss", miss_count, 32'd1);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/l1_dcache_controller.md
Name: l1_dcache_controller

Overview:
- Sequencing FSM for the direct-mapped, write-back, write-allocate L1 data cache.
- Owns the tag, valid and dirty arrays.
- Drives the cache data array through a word-wide port and services misses over the MMU memory interface (`mmu_mem_ready` handshake).
- Sits between the CPU load/store unit and the MMU.

Parameters:
- OFFSET_WIDTH, 5, log2 of block size in bytes; WORDS_PER_BLOCK = 2**(OFFSET_WIDTH-2).
- INDEX_WIDTH, 7, log2 of the number of cache lines.
- TAG_WIDTH, 32-OFFSET_WIDTH-INDEX_WIDTH, tag bits (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_read_enable  in  1  load request.
- cpu_write_enable  in  1  store request (full 32-bit word).
- cpu_address  in  32  byte address; bits [1:0] ignored.
- cpu_write_data  in  32  store data.
- cpu_read_data  out  32  load data, valid when cpu_ready=1.
- cpu_ready  out  1  one-cycle pulse: request completed.
- cache_miss  out  1  high while a miss is being serviced.
- data_index  out  INDEX_WIDTH  data-array line select.
- data_word  out  OFFSET_WIDTH-2  data-array word select.
- data_write_enable  out  1  data-array word write strobe.
- data_write_data  out  32  data-array write word.
- data_read_data  in  32  data-array read word (combinational read).
- mem_read_enable  out  1  MMU word read request.
- mem_write_enable  out  1  MMU word write request.
- mem_address  out  32  word-aligned MMU address.
- mem_write_data  out  32  MMU write word.
- mem_read_data  in  32  MMU read word, valid when mmu_mem_ready=1.
- mmu_mem_ready  in  1  MMU completes the current word this cycle.

Behaviour:

Request capture:
- A request is accepted in IDLE when read_enable or write_enable is high.
- Address and data are latched.
- If both enables are high, the write wins.
- CPU must hold the request until cpu_ready. Inputs are sampled only in IDLE.

States:
- IDLE: latch the request → COMPARE.
- COMPARE:
  - Hit = valid[idx] && tag[idx]==req_tag.
  - Read hit: cpu_read_data=data_read_data, cpu_ready=1 → IDLE.
  - Write hit: data_write_enable=1, dirty[idx]=1, cpu_ready=1 → IDLE.
  - Latency is 2 cycles from request to cpu_ready on a hit.
  - Miss with a dirty victim → WRITEBACK. Miss with a clean or invalid victim → ALLOCATE.
  - cache_miss rises on the cycle after COMPARE on a miss.
- WRITEBACK:
  - Word counter 0..WORDS_PER_BLOCK-1.
  - Drive mem_write_enable=1, mem_address={victim_tag,idx,cnt,2'b00}, mem_write_data=data_read_data.
  - Advance cnt on mmu_mem_ready. After the last word → ALLOCATE with cnt=0.
- ALLOCATE:
  - Drive mem_read_enable=1, mem_address={req_tag,idx,cnt,2'b00}.
  - On mmu_mem_ready: data_write_enable=1, data_write_data=mem_read_data, cnt++.
  - After the last word: tag[idx]=req_tag, valid=1, dirty=0 → COMPARE, which replays the request as a hit.
- mem enables stay asserted until mmu_mem_ready. Enables are deasserted for one cycle between words, so every word is a fresh request.

Counter and outputs:
- The counter wraps exactly at WORDS_PER_BLOCK-1. No extra transfers.
- data_index/data_word are combinational from state: COMPARE uses the request word; WRITEBACK/ALLOCATE use cnt.
- cache_miss is high in WRITEBACK and ALLOCATE and in the replay COMPARE; it clears with cpu_ready.

Reset:
- State=IDLE, cnt=0, all valid/dirty=0.
- Outputs: cpu_ready=0, cache_miss=0, all mem/data enables=0, data buses=0.
- Reset mid-refill abandons the transfer without a further mem request. The line stays invalid. Dirty data is lost by design.
- mmu_mem_ready outside WRITEBACK/ALLOCATE is ignored.

Optional Feature:
- Macro: DCACHE_PERF_COUNTERS_EN.
- Enabled: adds outputs hit_count[31:0] and miss_count[31:0].
  - Counted once per request at the first COMPARE; the replay COMPARE is not counted.
  - Wrap modulo 2**32. Cleared by reset.
- Disabled: ports and logic are absent.

Decomposition:
- Package l1_dcache_pkg:
  - FSM state encoding (IDLE, COMPARE, WRITEBACK, ALLOCATE).
  - Derived constants TAG_WIDTH and WORDS_PER_BLOCK.
  - Address field-extract functions.
- One sub-module: l1_dcache_tag_store (tag/valid/dirty arrays; sync write, async read; reset clears valid/dirty).

Test Plan:
- Reset, then read 0x0000_1000 → miss; 8 mem reads at 0x1000..0x101C.
  - With mmu_mem_ready after 3 cycles each, returns word 0 and cache_miss is cleared.
- Write 0xDEADBEEF to 0x1004 after the fill, then read 0x1004 → each gives cpu_ready 2 cycles after request, no mem traffic, data 0xDEADBEEF.
- Read 0x0001_1004 (same index, different tag) after the dirty line → 8 writes at 0x1000..0x101C with 0xDEADBEEF at 0x1004, then 8 reads at 0x11000..0x1101C.
- Reset asserted during the 4th refill word → next cycle all mem enables are 0. A re-read of the same address misses and refetches all 8 words.
- Both enables high with address 0x2000 → treated as a write: line allocated, dirty=1, no cpu_read_data update.
- With DCACHE_PERF_COUNTERS_EN: sequence miss, hit, hit → hit_count=2, miss_count=1. Without the macro, the build has no counter ports.
